// File: rtl/prog_loader.sv
// prog_loader: boot-time loader that streams a byte image into the unified
// instruction/data memory and then releases the processor from reset.
// Image: 16-bit word count N (LSB first), then N little-endian 32-bit words.
// Optional feature macro: LOADER_CHECKSUM_EN appends a 32-bit sum trailer
// that is checked before the processor is released.
module prog_loader #(
    parameter int              ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int              MAX_WORDS = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] Adr,
    output logic [31:0]       WriteData,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);
    localparam int          KW   = $clog2(MAX_WORDS + 1);
    localparam logic [15:0] MAXN = 16'(MAX_WORDS);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_HDR0, S_HDR1, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_HDR0, S_HDR1, S_DATA, S_WRITE, S_DONE, S_ERR} state_t;
`endif

    state_t            r_state;
    logic [7:0]        r_n_lo;
    logic [15:0]       r_n;
    logic [KW-1:0]     r_k;
    logic [1:0]        r_lane;
    logic [23:0]       r_asm;
    logic              r_in_ready;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_adr;
    logic [31:0]       r_wdata;
    logic              r_cpu_reset;
    logic              r_done;
    logic              r_error;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]       r_sum;
`endif

    logic              w_acc;
    logic [15:0]       w_hdr;
    logic [31:0]       w_word;
    logic              w_last;
    logic [ADDR_W-1:0] w_adr;

    assign w_acc  = in_valid & r_in_ready;
    assign w_hdr  = {in_data, r_n_lo};
    // lane 3 completes the word with the incoming byte, no extra cycle
    assign w_word = {in_data, r_asm};
    assign w_last = ((16'(r_k) + 16'd1) == r_n);
    assign w_adr  = BASE_ADDR + ADDR_W'({r_k, 2'b00});

    assign in_ready  = r_in_ready;
    assign MemWrite  = r_mem_write;
    assign Adr       = r_adr;
    assign WriteData = r_wdata;
    assign cpu_reset = r_cpu_reset;
    assign done      = r_done;
    assign error     = r_error;

    // Loader FSM; every output is a register so done/cpu_reset never glitch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_HDR0;
            r_n_lo      <= '0;
            r_n         <= '0;
            r_k         <= '0;
            r_lane      <= '0;
            r_asm       <= '0;
            r_in_ready  <= 1'b0;
            r_mem_write <= 1'b0;
            r_adr       <= BASE_ADDR;
            r_wdata     <= '0;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_sum       <= '0;
`endif
        end else begin
            case (r_state)
                S_HDR0: begin
                    r_in_ready <= 1'b1;
                    if (w_acc) begin
                        r_n_lo  <= in_data;
                        r_state <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (w_acc) begin
                        r_n <= w_hdr;
                        if (w_hdr == 16'd0 || w_hdr > MAXN) begin
                            r_state    <= S_ERR;
                            r_error    <= 1'b1;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_state <= S_DATA;
                            r_k     <= '0;
                            r_lane  <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_acc) begin
                        r_lane <= r_lane + 2'd1;
                        case (r_lane)
                            2'd0: r_asm[7:0]   <= in_data;
                            2'd1: r_asm[15:8]  <= in_data;
                            2'd2: r_asm[23:16] <= in_data;
                            default: begin
                                r_state     <= S_WRITE;
                                r_mem_write <= 1'b1;
                                r_adr       <= w_adr;
                                r_wdata     <= w_word;
                                r_in_ready  <= 1'b0;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    r_mem_write <= 1'b0;
                    r_k         <= r_k + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    r_sum       <= r_sum + r_wdata;
                    r_in_ready  <= 1'b1;
                    r_state     <= w_last ? S_CHK : S_DATA;
`else
                    if (w_last) begin
                        r_state     <= S_DONE;
                        r_done      <= 1'b1;
                        r_cpu_reset <= 1'b0;
                    end else begin
                        r_state    <= S_DATA;
                        r_in_ready <= 1'b1;
                    end
`endif
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (w_acc) begin
                        r_lane <= r_lane + 2'd1;
                        case (r_lane)
                            2'd0: r_asm[7:0]   <= in_data;
                            2'd1: r_asm[15:8]  <= in_data;
                            2'd2: r_asm[23:16] <= in_data;
                            default: begin
                                r_in_ready <= 1'b0;
                                if (w_word == r_sum) begin
                                    r_state     <= S_DONE;
                                    r_done      <= 1'b1;
                                    r_cpu_reset <= 1'b0;
                                end else begin
                                    r_state <= S_ERR;
                                    r_error <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
`endif
                S_DONE: r_in_ready <= 1'b0;
                S_ERR:  r_in_ready <= 1'b0;
                default: begin
                    r_state    <= S_ERR;
                    r_error    <= 1'b1;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized self-checking bench for prog_loader, with a
// byte-image reference model that derives expected writes and final status.
module tb_prog_loader;
    localparam int MAXW = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, MemWrite, cpu_reset, done, error;
    logic [31:0] Adr, WriteData;

    always #5 clk = ~clk;

    prog_loader dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .MemWrite(MemWrite), .Adr(Adr), .WriteData(WriteData),
        .cpu_reset(cpu_reset), .done(done), .error(error)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [31:0] wr_a[$];
    logic [31:0] wr_d[$];
    int          wr_c[$];

    logic [7:0]  img[$];
    logic [31:0] exp_a[$];
    logic [31:0] exp_d[$];
    bit          exp_err;
    int          nsend;
    int          done_cyc;

    always @(posedge clk) cyc++;

    // Capture every memory write; the loader must never offer ready while writing
    always @(negedge clk) begin
        if (reset === 1'b1 && MemWrite === 1'b1) begin
            wr_a.push_back(Adr);
            wr_d.push_back(WriteData);
            wr_c.push_back(cyc);
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL ready_during_write: in_ready=%b required 0", in_ready);
            end
        end
    end

    // Reference model: walk the image bytes by the format rules
    task automatic model();
        logic [15:0] n;
        logic [31:0] w, sum;
        n = {img[1], img[0]};
        exp_a = {};
        exp_d = {};
        sum = 0;
        if (n == 0 || n > MAXW) begin
            exp_err = 1'b1;
            nsend = 2;
        end else begin
            for (int i = 0; i < int'(n); i++) begin
                w = {img[2+4*i+3], img[2+4*i+2], img[2+4*i+1], img[2+4*i]};
                exp_a.push_back(32'(4 * i));
                exp_d.push_back(w);
                sum = sum + w;
            end
            nsend = 2 + 4 * int'(n);
`ifdef LOADER_CHECKSUM_EN
            w = {img[nsend+3], img[nsend+2], img[nsend+1], img[nsend]};
            exp_err = (w != sum);
            nsend = nsend + 4;
`else
            exp_err = 1'b0;
`endif
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) img.push_back(w[8*i +: 8]);
    endtask

    task automatic mk_img(input int n, input bit good_sum);
        logic [31:0] w, sum;
        img = {};
        sum = 0;
        img.push_back(8'(n));
        img.push_back(8'(n >> 8));
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            sum = sum + w;
            push_word(w);
        end
`ifdef LOADER_CHECKSUM_EN
        push_word(good_sum ? sum : sum ^ (32'h1 << $urandom_range(0, 31)));
`else
        if (good_sum) sum = 0;
`endif
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int cnt;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        cnt = 0;
        while (in_ready !== 1'b1 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        total++;
        if (cnt >= 200) begin
            bad++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        total += 7;
        if (in_ready !== 1'b0)  begin bad++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
        if (MemWrite !== 1'b0)  begin bad++; $display("FAIL rst_memwrite: got %b required 0", MemWrite); end
        if (Adr !== 32'h0)      begin bad++; $display("FAIL rst_adr: got %h required 0", Adr); end
        if (WriteData !== 32'h0) begin bad++; $display("FAIL rst_wdata: got %h required 0", WriteData); end
        if (cpu_reset !== 1'b1) begin bad++; $display("FAIL rst_cpu_reset: got %b required 1", cpu_reset); end
        if (done !== 1'b0)      begin bad++; $display("FAIL rst_done: got %b required 0", done); end
        if (error !== 1'b0)     begin bad++; $display("FAIL rst_error: got %b required 0", error); end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b required 1", in_ready); end
    endtask

    // Send the image, then check writes, final status and post-load idling
    task automatic run_image(input string name, input int gapmax, input bit chk_done_timing);
        int nw;
        model();
        wr_a = {};
        wr_d = {};
        wr_c = {};
        for (int i = 0; i < nsend; i++)
            send_byte(img[i], (gapmax > 0) ? $urandom_range(0, gapmax) : 0);
        @(negedge clk);
        in_valid = 1'b0;
        for (int w = 0; w < 40 && done !== 1'b1 && error !== 1'b1; w++) @(negedge clk);
        done_cyc = cyc;
        repeat (2) @(negedge clk);
        total += 5;
        if (done !== !exp_err)     begin bad++; $display("FAIL %s done: got %b required %b", name, done, !exp_err); end
        if (error !== exp_err)     begin bad++; $display("FAIL %s error: got %b required %b", name, error, exp_err); end
        if (cpu_reset !== exp_err) begin bad++; $display("FAIL %s cpu_reset: got %b required %b", name, cpu_reset, exp_err); end
        if (in_ready !== 1'b0)     begin bad++; $display("FAIL %s in_ready_end: got %b required 0", name, in_ready); end
        if (wr_a.size() != exp_a.size()) begin
            bad++;
            $display("FAIL %s write_count: got %0d required %0d", name, wr_a.size(), exp_a.size());
        end
        nw = (wr_a.size() < exp_a.size()) ? wr_a.size() : exp_a.size();
        for (int i = 0; i < nw; i++) begin
            total++;
            if (wr_a[i] !== exp_a[i] || wr_d[i] !== exp_d[i]) begin
                bad++;
                $display("FAIL %s write%0d: got %h@%h required %h@%h", name, i, wr_d[i], wr_a[i], exp_d[i], exp_a[i]);
            end
        end
`ifndef LOADER_CHECKSUM_EN
        if (chk_done_timing && nw > 0) begin
            total++;
            if (done_cyc != wr_c[nw-1] + 1) begin
                bad++;
                $display("FAIL %s done_timing: got cycle %0d required %0d", name, done_cyc, wr_c[nw-1] + 1);
            end
        end
`else
        if (chk_done_timing) nw = nw + 0;
`endif
        // trailing bytes must be refused
        nw = wr_a.size();
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 8'h5A;
        repeat (6) begin
            @(negedge clk);
            total++;
            if (in_ready !== 1'b0) begin bad++; $display("FAIL %s trailing_ready: got %b required 0", name, in_ready); end
        end
        in_valid = 1'b0;
        total++;
        if (wr_a.size() != nw) begin bad++; $display("FAIL %s trailing_write: got %0d writes required %0d", name, wr_a.size(), nw); end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_basic();
        img = {8'h02, 8'h00, 8'h01, 8'h00, 8'hA0, 8'hE3, 8'h02, 8'h10, 8'hA0, 8'hE3};
`ifdef LOADER_CHECKSUM_EN
        push_word(32'hE3A00001 + 32'hE3A01002);
`endif
        do_reset();
        run_image("basic", 0, 1'b1);
        total++;
        if (wr_c.size() == 2 && wr_c[1] - wr_c[0] != 5) begin
            bad++;
            $display("FAIL basic_throughput: got %0d cycles required 5", wr_c[1] - wr_c[0]);
        end
    endtask

    task automatic test_zero_hdr();
        do_reset();
        wr_a = {};
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (error !== 1'b1) begin bad++; $display("FAIL zero_hdr_error_next: got %b required 1", error); end
        img = {8'h00, 8'h00};
        do_reset();
        run_image("zero_hdr", 0, 1'b0);
    endtask

    task automatic test_max();
        do_reset();
        img = {8'd65, 8'h00};
        run_image("over_max", 0, 1'b0);
        do_reset();
        mk_img(MAXW, 1'b1);
        run_image("max", 0, 1'b1);
        total++;
        if (wr_a.size() > 0 && wr_a[wr_a.size()-1] !== 32'hFC) begin
            bad++;
            $display("FAIL max_last_adr: got %h required 000000fc", wr_a[wr_a.size()-1]);
        end
    endtask

    task automatic test_gaps();
        do_reset();
        img = {8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
`ifdef LOADER_CHECKSUM_EN
        push_word(32'h12345678);
`endif
        model();
        wr_a = {};
        wr_d = {};
        wr_c = {};
        for (int i = 0; i < nsend; i++) send_byte(img[i], 2);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        total += 3;
        if (wr_a.size() != 1) begin bad++; $display("FAIL gaps_count: got %0d required 1", wr_a.size()); end
        else if (wr_d[0] !== 32'h12345678) begin bad++; $display("FAIL gaps_word: got %h required 12345678", wr_d[0]); end
        if (done !== 1'b1) begin bad++; $display("FAIL gaps_done: got %b required 1", done); end
        if (cpu_reset !== 1'b0) begin bad++; $display("FAIL gaps_cpu_reset: got %b required 0", cpu_reset); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        wr_a = {};
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        total += 3;
        if (cpu_reset !== 1'b1) begin bad++; $display("FAIL mid_reset_cpu: got %b required 1", cpu_reset); end
        if (in_ready !== 1'b0)  begin bad++; $display("FAIL mid_reset_ready: got %b required 0", in_ready); end
        if (wr_a.size() != 0)   begin bad++; $display("FAIL mid_reset_writes: got %0d required 0", wr_a.size()); end
        do_reset();
        img = {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef LOADER_CHECKSUM_EN
        push_word(32'hDEADBEEF);
`endif
        run_image("after_reset", 0, 1'b1);
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 8; it++) begin
            do_reset();
            case ($urandom_range(0, 5))
                0: begin img = {8'h00, 8'h00}; end
                1: begin n = $urandom_range(MAXW + 1, 300); img = {8'(n), 8'(n >> 8)}; end
                default: begin n = $urandom_range(1, 8); mk_img(n, $urandom_range(0, 3) != 0); end
            endcase
            run_image("random", 3, 1'b0);
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        do_reset();
        img = {8'h02, 8'h00};
        push_word(32'h1);
        push_word(32'h2);
        push_word(32'h3);
        run_image("chk_good", 0, 1'b0);
        do_reset();
        img = {8'h02, 8'h00};
        push_word(32'h1);
        push_word(32'h2);
        push_word(32'h4);
        run_image("chk_bad", 0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_hdr();
        test_max();
        test_gaps();
        test_mid_reset();
        test_random();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
